// File: rtl/radiant_trig_majority.sv
// Majority-coincidence trigger: per-channel stretch windows, two-stage popcount, holdoff and re-arm.
// Optional channel masking is compiled in with RADIANT_TRIG_MASK_EN.
`timescale 1ns/1ps
module radiant_trig_majority #(
   parameter int NCHAN        = 24,
   parameter int WINDOW_BITS  = 8,
   parameter int HOLDOFF_BITS = 8,
   parameter int THRESH_BITS  = 5
) (
   input  logic                    fast_clk_i,
   input  logic                    rst_i,
   input  logic [NCHAN-1:0]        trig_i,
   input  logic [NCHAN-1:0]        mask_i,
   input  logic [WINDOW_BITS-1:0]  window_i,
   input  logic [THRESH_BITS-1:0]  thresh_i,
   input  logic [HOLDOFF_BITS-1:0] holdoff_i,
   input  logic                    enable_i,
   output logic                    trig_o,
   output logic                    busy_o,
   output logic [NCHAN-1:0]        chan_o
);

   localparam int GRP_SZ = 6;
   localparam int NGRP   = (NCHAN + GRP_SZ - 1) / GRP_SZ;
   localparam int PAD_W  = NGRP * GRP_SZ;
   localparam int GRP_W  = 3;

   typedef enum logic [1:0] {ST_IDLE, ST_HOLDOFF, ST_REARM} state_t;

   logic [WINDOW_BITS-1:0]  str_cnt_q [NCHAN];
   logic [WINDOW_BITS-1:0]  str_cnt_d [NCHAN];
   logic [WINDOW_BITS-1:0]  win_load;
   logic [NCHAN-1:0]        active;

   logic [PAD_W-1:0]        active_pad;
   logic [GRP_W-1:0]        grp_sum_d [NGRP];
   logic [GRP_W-1:0]        grp_sum_p1_q [NGRP];
   logic [NCHAN-1:0]        active_p1_q;

   logic [THRESH_BITS-1:0]  count_d;
   logic [THRESH_BITS-1:0]  count_p2_q;
   logic [NCHAN-1:0]        active_p2_q;

   logic                    hit_d;
   logic                    hit_p3_q;
   logic [NCHAN-1:0]        active_p3_q;

   state_t                  state_q;
   logic [HOLDOFF_BITS-1:0] hold_q;
   logic                    trig_q;
   logic                    busy_q;
   logic [NCHAN-1:0]        chan_q;

   // Stretch counters: a fresh pulse always reloads, even on the cycle the count would expire
   always_comb begin
      win_load = (window_i == '0) ? WINDOW_BITS'(1) : window_i;
      for (int n = 0; n < NCHAN; n++) begin
         active[n] = (str_cnt_q[n] != '0);
         if (trig_i[n])
            str_cnt_d[n] = win_load;
         else if (str_cnt_q[n] != '0)
            str_cnt_d[n] = str_cnt_q[n] - WINDOW_BITS'(1);
         else
            str_cnt_d[n] = '0;
`ifdef RADIANT_TRIG_MASK_EN
         if (mask_i[n])
            str_cnt_d[n] = '0;
`endif
      end
   end

`ifndef RADIANT_TRIG_MASK_EN
   logic unused_mask;
   assign unused_mask = ^mask_i;
`endif

   always_ff @(posedge fast_clk_i) begin
      for (int n = 0; n < NCHAN; n++) begin
         if (rst_i)
            str_cnt_q[n] <= '0;
         else
            str_cnt_q[n] <= str_cnt_d[n];
      end
   end

   // Stage 1: partial counts over groups of six channels
   always_comb begin
      active_pad = PAD_W'(active);
      for (int g = 0; g < NGRP; g++) begin
         grp_sum_d[g] = '0;
         for (int i = 0; i < GRP_SZ; i++)
            grp_sum_d[g] = grp_sum_d[g] + GRP_W'(active_pad[g*GRP_SZ+i]);
      end
   end

   // Stage 2: final count; stage 3: threshold compare
   always_comb begin
      count_d = '0;
      for (int g = 0; g < NGRP; g++)
         count_d = count_d + THRESH_BITS'(grp_sum_p1_q[g]);
      hit_d = (thresh_i != '0) && (count_p2_q >= thresh_i);
   end

   always_ff @(posedge fast_clk_i) begin
      if (rst_i) begin
         for (int g = 0; g < NGRP; g++)
            grp_sum_p1_q[g] <= '0;
         active_p1_q <= '0;
         count_p2_q  <= '0;
         active_p2_q <= '0;
         hit_p3_q    <= 1'b0;
         active_p3_q <= '0;
      end else begin
         for (int g = 0; g < NGRP; g++)
            grp_sum_p1_q[g] <= grp_sum_d[g];
         active_p1_q <= active;
         count_p2_q  <= count_d;
         active_p2_q <= active_p1_q;
         hit_p3_q    <= hit_d;
         active_p3_q <= active_p2_q;
      end
   end

   // Zero holdoff skips straight to REARM so back-to-back triggers can be two cycles apart
   always_ff @(posedge fast_clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         hold_q  <= '0;
         trig_q  <= 1'b0;
         busy_q  <= 1'b0;
         chan_q  <= '0;
      end else begin
         trig_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (hit_p3_q && enable_i) begin
                  trig_q  <= 1'b1;
                  busy_q  <= 1'b1;
                  chan_q  <= active_p3_q;
                  hold_q  <= holdoff_i;
                  state_q <= (holdoff_i == '0) ? ST_REARM : ST_HOLDOFF;
               end
            end
            ST_HOLDOFF: begin
               hold_q <= hold_q - HOLDOFF_BITS'(1);
               if (hold_q <= HOLDOFF_BITS'(1))
                  state_q <= ST_REARM;
            end
            ST_REARM: begin
               if (!hit_p3_q) begin
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign trig_o = trig_q;
   assign busy_o = busy_q;
   assign chan_o = chan_q;

`ifndef SYNTHESIS
   trig_single_a: assert property (@(posedge fast_clk_i) disable iff (rst_i) trig_q |=> !trig_q);
   count_range_a: assert property (@(posedge fast_clk_i) disable iff (rst_i)
                                   count_p2_q <= THRESH_BITS'(NCHAN));
`endif

endmodule

// File: tb/tb_radiant_trig_majority.sv
// Randomized and directed bench for radiant_trig_majority against a time-based behavioural model.
`timescale 1ns/1ps
module tb_radiant_trig_majority;

   localparam int NCHAN = 24;

   logic              clk;
   logic              rst;
   logic [NCHAN-1:0]  trig;
   logic [NCHAN-1:0]  mask;
   logic [7:0]        window;
   logic [4:0]        thresh;
   logic [7:0]        holdoff;
   logic              enable;
   logic              trig_o;
   logic              busy_o;
   logic [NCHAN-1:0]  chan_o;

   radiant_trig_majority #(
      .NCHAN(NCHAN), .WINDOW_BITS(8), .HOLDOFF_BITS(8), .THRESH_BITS(5)
   ) dut (
      .fast_clk_i(clk), .rst_i(rst), .trig_i(trig), .mask_i(mask),
      .window_i(window), .thresh_i(thresh), .holdoff_i(holdoff), .enable_i(enable),
      .trig_o(trig_o), .busy_o(busy_o), .chan_o(chan_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Model: each channel remembers its last accepted pulse edge and the window it loaded
   int               lp [NCHAN];
   int               lw [NCHAN];
   bit               lv [NCHAN];
   logic [NCHAN-1:0] hist [4];
   bit               hit_cur;
   bit               m_busy;
   int               rearm_from;
   bit               exp_trig;
   logic [NCHAN-1:0] exp_chan;
   int               edge_no = 0;
   int               n_trig = 0;
   int               last_trig_edge = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at edge %0d", tag, got, exp, edge_no);
      end
   endtask

   task automatic model_step();
      logic [NCHAN-1:0] act;
      bit hit_next;
      edge_no++;
      if (rst) begin
         for (int n = 0; n < NCHAN; n++) lv[n] = 0;
         for (int i = 0; i < 4; i++) hist[i] = '0;
         hit_cur  = 0;
         m_busy   = 0;
         exp_trig = 0;
         exp_chan = '0;
      end else begin
         exp_trig = 0;
         if (!m_busy) begin
            if (hit_cur && enable) begin
               exp_trig   = 1;
               m_busy     = 1;
               rearm_from = edge_no + int'(holdoff);
               exp_chan   = hist[3];
            end
         end else if (edge_no > rearm_from && !hit_cur) begin
            m_busy = 0;
         end
         hit_next = (thresh != 0) && ($countones(hist[2]) >= int'(thresh));
         for (int n = 0; n < NCHAN; n++) begin
`ifdef RADIANT_TRIG_MASK_EN
            if (mask[n]) lv[n] = 0; else
`endif
            if (trig[n]) begin
               lv[n] = 1;
               lp[n] = edge_no;
               lw[n] = (window == 0) ? 1 : int'(window);
            end
            act[n] = lv[n] && (edge_no - lp[n] < lw[n]);
         end
         hist[3] = hist[2];
         hist[2] = hist[1];
         hist[1] = hist[0];
         hist[0] = act;
         hit_cur = hit_next;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      chk("trig_o", {31'd0, trig_o}, {31'd0, exp_trig});
      chk("busy_o", {31'd0, busy_o}, {31'd0, m_busy});
      chk("chan_o", 32'(chan_o), 32'(exp_chan));
      if (trig_o === 1'b1) begin
         n_trig++;
         last_trig_edge = edge_no;
      end
   endtask

   task automatic idle(input int n);
      trig = '0;
      repeat (n) tick();
   endtask

   task automatic pulse(input logic [NCHAN-1:0] v);
      trig = v;
      tick();
      trig = '0;
   endtask

   task automatic cfg(input int w, input int t, input int h);
      window  = 8'(w);
      thresh  = 5'(t);
      holdoff = 8'(h);
   endtask

   int n0;
   int ek;
   logic [NCHAN-1:0] v;

   initial begin
      rst = 1'b1; trig = '0; mask = '0; enable = 1'b1;
      cfg(4, 3, 0);
      repeat (3) tick();
      chk("rst_trig", {31'd0, trig_o}, 32'd0);
      chk("rst_busy", {31'd0, busy_o}, 32'd0);
      chk("rst_chan", 32'(chan_o), 32'd0);
      rst = 1'b0;
      idle(10);

      // three channels on consecutive edges, window 4
      cfg(4, 3, 0); n0 = n_trig;
      pulse(24'h000001); pulse(24'h000020); pulse(24'h000200); ek = edge_no;
      idle(15);
      chk("A_count", 32'(n_trig - n0), 32'd1);
      chk("A_latency", 32'(last_trig_edge - ek), 32'd4);
      chk("A_chan", 32'(chan_o), 32'h000221);

      // window edge: 4 edges apart misses, 3 edges apart coincides
      cfg(4, 2, 0); n0 = n_trig;
      pulse(24'h000002); idle(3); pulse(24'h000004);
      idle(15);
      chk("B_miss", 32'(n_trig - n0), 32'd0);
      pulse(24'h000002); idle(2); pulse(24'h000004);
      idle(15);
      chk("B_hit", 32'(n_trig - n0), 32'd1);
      chk("B_chan", 32'(chan_o), 32'h000006);

      // sustained hits during holdoff and rearm give one trigger
      cfg(4, 2, 20); n0 = n_trig;
      for (int i = 0; i < 20; i++) begin
         trig = 24'h000018; tick();
         trig = '0; tick();
      end
      chk("C_busy_held", {31'd0, busy_o}, 32'd1);
      idle(30);
      chk("C_busy_clear", {31'd0, busy_o}, 32'd0);
      chk("C_count", 32'(n_trig - n0), 32'd1);

      // masked channel 0
      cfg(4, 2, 0); mask = 24'h000001; n0 = n_trig;
      pulse(24'h000003);
      idle(15);
`ifdef RADIANT_TRIG_MASK_EN
      chk("D_masked", 32'(n_trig - n0), 32'd0);
`else
      chk("D_unmasked", 32'(n_trig - n0), 32'd1);
      chk("D_chan", 32'(chan_o), 32'h000003);
`endif
      mask = '0;

      // threshold extremes
      cfg(4, 0, 0); n0 = n_trig;
      pulse(24'hFFFFFF);
      idle(15);
      chk("E_thresh0", 32'(n_trig - n0), 32'd0);
      cfg(4, 24, 0);
      pulse(24'hFFFFFF);
      idle(15);
      chk("E_thresh24", 32'(n_trig - n0), 32'd1);
      chk("E_chan", 32'(chan_o), 32'hFFFFFF);

      // reset in the middle of holdoff with windows still open
      cfg(20, 2, 50); n0 = n_trig;
      pulse(24'h000018); idle(6);
      chk("F_busy_before", {31'd0, busy_o}, 32'd1);
      rst = 1'b1; tick(); rst = 1'b0;
      chk("F_busy_rst", {31'd0, busy_o}, 32'd0);
      chk("F_chan_rst", 32'(chan_o), 32'd0);
      pulse(24'h000018); ek = edge_no;
      idle(6);
      chk("F_count", 32'(n_trig - n0), 32'd2);
      chk("F_latency", 32'(last_trig_edge - ek), 32'd4);
      chk("F_chan", 32'(chan_o), 32'h000018);
      rst = 1'b1; tick(); rst = 1'b0;

      // randomized traffic with live parameter changes
      for (int blk = 0; blk < 60; blk++) begin
         cfg($urandom_range(0, 6), $urandom_range(0, 5), $urandom_range(0, 8));
         enable = ($urandom_range(0, 4) != 0);
         v = '0;
         for (int n = 0; n < NCHAN; n++)
            if ($urandom_range(0, 7) == 0) v[n] = 1'b1;
         mask = v;
         for (int c = 0; c < 50; c++) begin
            v = '0;
            for (int n = 0; n < NCHAN; n++)
               if ($urandom_range(0, 15) == 0) v[n] = 1'b1;
            trig = v;
            rst  = ($urandom_range(0, 199) == 0);
            tick();
         end
         rst = 1'b0;
      end
      idle(20);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
